// File: rtl/rr_arbiter7_pkg.sv
// Shared definitions for the 7-way round-robin arbiter.
package rr_arbiter7_pkg;

    localparam int N_REQ = 7;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Reduce a value in 0..13 to a requester index 0..6.
    function automatic logic [IDX_W-1:0] wrap7(input logic [IDX_W:0] v);
        logic [IDX_W:0] r;
        r = (v >= 4'd7) ? (v - 4'd7) : v;
        return r[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter7_pick7.sv
// Round-robin selector: first set request bit strictly after ptr, wrapping 6->0.
module rr_pick7
    import rr_arbiter7_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] oh
);

    logic [IDX_W-1:0] base;   // first index examined
    logic [N_REQ-1:0] rot;    // req rotated so that bit 0 is 'base'
    logic [IDX_W-1:0] off;    // offset of winner within rot

    assign base = (ptr >= IDX_W'(N_REQ - 1)) ? '0 : ptr + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[wrap7({1'b0, base} + (IDX_W + 1)'(gi))];
        end
    endgenerate

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
    end

    assign any = |req;
    assign idx = any ? wrap7({1'b0, base} + {1'b0, off}) : '0;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_oh
            assign oh[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter7.sv
// 7-way round-robin arbiter with done/timeout release and pending-request count.
module rr_arbiter7
    import rr_arbiter7_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_oh,
    output logic             timeout,
    output logic [IDX_W-1:0] pend_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [TW-1:0]    hold_q, hold_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] pend_q;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             to_hit;

    rr_pick7 u_pick (
        .req (req),
        .ptr (last_ptr_q),
        .any (pick_any),
        .idx (pick_idx),
        .oh  (pick_oh)
    );

    // Timeout fires on the TIMEOUT-th cycle of a tenure (hold counter starts at 0).
    assign to_hit = (TIMEOUT != 0) && (hold_q == TW'(TIMEOUT - 1));

    // Popcount of req as a balanced adder tree.
    logic [1:0] s01, s23, s45;
    logic [2:0] s0123, s456, pop;
    assign s01   = {1'b0, req[0]} + {1'b0, req[1]};
    assign s23   = {1'b0, req[2]} + {1'b0, req[3]};
    assign s45   = {1'b0, req[4]} + {1'b0, req[5]};
    assign s0123 = {1'b0, s01} + {1'b0, s23};
    assign s456  = {1'b0, s45} + {2'b00, req[6]};
    assign pop   = s0123 + s456;

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_d     = state_q;
        last_ptr_d  = last_ptr_q;
        hold_d      = hold_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_oh_d    = gnt_oh_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d     = ST_BUSY;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                    gnt_oh_d    = pick_oh;
                    hold_d      = '0;
                end
            end
            ST_BUSY: begin
                hold_d = hold_q + 1'b1;
                if (done || to_hit) begin
                    state_d     = ST_IDLE;
                    last_ptr_d  = gnt_idx_q;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    gnt_oh_d    = '0;
                    hold_d      = '0;
                    // done takes precedence, so a coincident timeout is silent
                    timeout_d   = !done;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; pend count tracks req every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_ptr_q  <= IDX_W'(N_REQ - 1);
            hold_q      <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_oh_q    <= '0;
            timeout_q   <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_ptr_q  <= last_ptr_d;
            hold_q      <= hold_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_oh_q    <= gnt_oh_d;
            timeout_q   <= timeout_d;
            pend_q      <= pop;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_oh    = gnt_oh_q;
    assign timeout   = timeout_q;
    assign pend_cnt  = pend_q;

endmodule

// File: tb/tb_rr_arbiter7.sv
// Directed-vector bench for rr_arbiter7, plus a standalone sweep of rr_pick7.
module tb_rr_arbiter7;
    import rr_arbiter7_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [6:0] gnt_oh;
    logic       timeout;
    logic [2:0] pend_cnt;

    always #5 clk = ~clk;

    rr_arbiter7 #(.TIMEOUT(15), .TW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh),
        .timeout   (timeout),
        .pend_cnt  (pend_cnt)
    );

    logic [6:0] p_req;
    logic [2:0] p_ptr;
    logic       p_any;
    logic [2:0] p_idx;
    logic [6:0] p_oh;

    rr_pick7 u_pick (
        .req (p_req),
        .ptr (p_ptr),
        .any (p_any),
        .idx (p_idx),
        .oh  (p_oh)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [6:0] req;
        logic       done;
        logic       ev;
        logic [2:0] eidx;
        logic       eto;
        logic [2:0] epend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] q, input logic d,
                       input logic ev, input logic [2:0] ei, input logic eto,
                       input logic [2:0] ep);
        vec_t v;
        v.rst = r; v.req = q; v.done = d;
        v.ev = ev; v.eidx = ei; v.eto = eto; v.epend = ep;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [6:0] eoh;
        eoh = v.ev ? (7'd1 << v.eidx) : 7'd0;
        n_vec++;
        if ({gnt_valid, gnt_idx, gnt_oh, timeout, pend_cnt} !==
            {v.ev, v.eidx, eoh, v.eto, v.epend}) begin
            n_err++;
            $display("FAIL vec%0d: got valid=%0b idx=%0d oh=%b to=%0b pend=%0d, exp valid=%0b idx=%0d oh=%b to=%0b pend=%0d",
                     i, gnt_valid, gnt_idx, gnt_oh, timeout, pend_cnt,
                     v.ev, v.eidx, eoh, v.eto, v.epend);
        end else begin
            $display("vec%0d ok: rst=%0b req=%b done=%0b -> valid=%0b idx=%0d to=%0b pend=%0d",
                     i, v.rst, v.req, v.done, gnt_valid, gnt_idx, timeout, pend_cnt);
        end
    endtask

    initial begin
        logic [2:0] seq8 [8];
        logic [2:0] seq4 [4];
        logic [2:0] prev_pend;
        int         walk [15];

        seq8 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        seq4 = '{3'd2, 3'd5, 3'd2, 3'd5};

        // All requesting, three-cycle tenures with done on the third cycle.
        add(1, 7'h7F, 0, 0, 0, 0, 0);
        foreach (seq8[k]) begin
            add(0, 7'h7F, 0, 1, seq8[k], 0, 7);
            add(0, 7'h7F, 0, 1, seq8[k], 0, 7);
            add(0, 7'h7F, 1, 0, 0,       0, 7);
        end
        // Two requesters alternate; then a single requester repeats with one idle cycle.
        foreach (seq4[k]) begin
            add(0, 7'h24, 0, 1, seq4[k], 0, 2);
            add(0, 7'h24, 1, 0, 0,       0, 2);
        end
        for (int k = 0; k < 3; k++) begin
            add(0, 7'h04, 0, 1, 2, 0, 1);
            add(0, 7'h04, 1, 0, 0, 0, 1);
        end
        // Timeout on idx 3 after 15 busy cycles, then rotation continues at 4.
        add(1, 7'h08, 0, 0, 0, 0, 0);
        add(0, 7'h08, 0, 1, 3, 0, 1);
        for (int k = 0; k < 14; k++) add(0, 7'h08, 0, 1, 3, 0, 1);
        add(0, 7'h08, 0, 0, 0, 1, 1);
        add(0, 7'h7F, 0, 1, 4, 0, 7);
        // done coinciding with the 15th busy cycle: release without timeout.
        for (int k = 0; k < 14; k++) add(0, 7'h7F, 0, 1, 4, 0, 7);
        add(0, 7'h7F, 1, 0, 0, 0, 7);
        add(0, 7'h7F, 0, 1, 5, 0, 7);
        // Reset while busy on idx 4; pointer returns to 6 so next grant is 0.
        add(1, 7'h10, 0, 0, 0, 0, 0);
        add(0, 7'h10, 0, 1, 4, 0, 1);
        add(0, 7'h10, 0, 1, 4, 0, 1);
        add(1, 7'h7F, 0, 0, 0, 0, 0);
        add(0, 7'h7F, 0, 1, 0, 0, 7);

        rst = 1'b1; req = '0; done = 1'b0;
        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            check_vec(i, vecs[i]);
        end

        // pend_cnt walk 0..7..0, five cycles per step, grants cycling underneath.
        walk = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
        rst = 1'b0; done = 1'b1;
        prev_pend = 3'd7;
        foreach (walk[s]) begin
            int m;
            m = (1 << walk[s]) - 1;
            req = 7'(m);
            #1;
            n_vec++;
            if (pend_cnt !== prev_pend) begin
                n_err++;
                $display("FAIL pend_before step%0d: got %0d exp %0d", s, pend_cnt, prev_pend);
            end
            for (int c = 0; c < 5; c++) begin
                tick();
                n_vec++;
                if (pend_cnt !== 3'(walk[s])) begin
                    n_err++;
                    $display("FAIL pend step%0d cyc%0d: got %0d exp %0d", s, c, pend_cnt, walk[s]);
                end
            end
            $display("pend step%0d req=%b pend=%0d", s, req, pend_cnt);
            prev_pend = 3'(walk[s]);
        end

        // Standalone selector sweep against a linear-search reference.
        for (int p = 0; p < 7; p++) begin
            int row_err;
            row_err = 0;
            for (int r = 0; r < 128; r++) begin
                logic       e_any;
                logic [2:0] e_idx;
                logic [6:0] e_oh;
                logic [6:0] rv;
                rv = 7'(r);
                p_req = rv;
                p_ptr = 3'(p);
                #1;
                e_any = (rv != 7'd0);
                e_idx = 3'd0;
                for (int k = 7; k >= 1; k--) begin
                    int j;
                    j = (p + k) % 7;
                    if (rv[j]) e_idx = 3'(j);
                end
                e_oh = e_any ? (7'd1 << e_idx) : 7'd0;
                n_vec++;
                if ({p_any, p_idx, p_oh} !== {e_any, e_idx, e_oh}) begin
                    n_err++;
                    row_err++;
                    $display("FAIL pick ptr=%0d req=%b: got any=%0b idx=%0d oh=%b exp any=%0b idx=%0d oh=%b",
                             p, rv, p_any, p_idx, p_oh, e_any, e_idx, e_oh);
                end
            end
            $display("pick ptr=%0d swept 128 request patterns, %0d bad", p, row_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter7.md
Name: rr_arbiter7

Overview:
- Round-robin arbiter that shares one resource among 7 requesters (req[6:0]).
- Issues one grant at a time, as both a 3-bit index and a one-hot vector. Holds the grant until the resource signals done or a timeout expires.
- Also reports the number of pending requests (0..7, 3 bits) for the status display logic.
- Sits between the requester bank and the shared datapath unit.

Parameters:
- N_REQ, 7, number of requesters; fixed at 7 so the index fits 3 bits.
- TIMEOUT, 15, maximum cycles a grant is held without done; 0 disables the timeout.
- TW, 4, width of the hold counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  7  request vector; bit i high = requester i wants the resource
- done  input  1  resource finished the current grant; sampled only in state BUSY
- gnt_valid  output  1  a grant is active
- gnt_idx  output  3  index of the granted requester; 0 when gnt_valid=0
- gnt_oh  output  7  one-hot grant; all zero when gnt_valid=0
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout
- pend_cnt  output  3  registered popcount of req, sampled every cycle

Behaviour:
- Reset: all outputs 0, state IDLE, last_ptr=6 (so the first search starts at index 0), hold counter 0.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0, select the first set bit searching from last_ptr+1 upward, wrapping 6->0.
  - Next cycle: state BUSY, gnt_valid=1, gnt_idx/gnt_oh registered, hold counter 0.
  - Latency from request to grant is 1 cycle.
- BUSY:
  - Hold counter increments every cycle.
  - done=1: last_ptr<=gnt_idx, grant drops next cycle, return to IDLE. The freed requester can be re-granted no earlier than 2 cycles later, and only if no other requester is pending.
  - Hold counter reaches TIMEOUT (TIMEOUT!=0) without done: same release as done, plus timeout=1 for one cycle. If done and timeout coincide, done wins and timeout stays 0.
  - The granted requester dropping req while BUSY does not revoke the grant; only done or timeout releases it.
  - New requests arriving in BUSY are queued implicitly by req level; there is no storage.
- Fairness:
  - The pointer rotates past the last granted index.
  - With all 7 requesting continuously, grants go 0,1,2,3,4,5,6,0,...
  - Any continuously asserted requester is granted within 6 grant tenures.
- Single requester: the same index is re-granted each tenure, with 1 IDLE cycle between tenures.
- req=0 in IDLE: stay IDLE, outputs 0.
- pend_cnt:
  - Registered popcount of req, updated every cycle regardless of state.
  - Value 7 when all bits are set. The 3-bit count never overflows since N_REQ=7.
- Reset mid-grant: returns to IDLE next cycle; the grant is dropped without a timeout pulse and last_ptr returns to 6.
- Outputs gnt_valid, gnt_idx, gnt_oh and timeout are registered; there is no combinational path from req to outputs.

Decomposition:
- Shared package holds: state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1), N_REQ=7, IDX_W=3.
- Sub-module rr_pick7 is combinational. Inputs: req[6:0] and ptr[2:0]. Outputs: any, idx[2:0], oh[6:0].
- rr_pick7 implements the rotate, priority-encode and un-rotate steps, so it can be tested standalone against a reference model.
- Popcount is inline in the top level: an adder tree of 7 one-bit inputs.

Test Plan:
- Reset with req=7'h7F: after rst drops, the first grant is idx=0 one cycle later and pend_cnt=7. Pulse done every 3rd cycle -> idx sequence 0,1,2,3,4,5,6,0.
- req=7'b0100100 with done pulsed on each grant -> idx alternates 2,5,2,5. Drop req[5] -> only 2 is granted, with 1 IDLE cycle between tenures.
- Grant idx=3 with done held low for TIMEOUT=15 cycles -> gnt_valid falls after cycle 15 and timeout pulses once. With req=7'h7F, the next grant is idx=4.
- done and timeout coincide on cycle 15 -> release occurs and timeout stays 0.
- Assert rst while BUSY with idx=4 -> next cycle gnt_valid=0, gnt_oh=0, state IDLE. With req=7'h7F, the next grant is idx=0.
- Walk req from 0 to 7'h7F one bit at a time every 5 cycles, then clear bits one at a time -> pend_cnt follows 0..7..0, each value 1 cycle after req changes, independent of grant state.
